if_id_stage: RTL
================

Name: if_id_stage

Overview:
- IF/ID pipeline boundary directly downstream of instruction fetch.
- Captures the fetched instruction, the word-unit PC+4 and the eret-return flag for the decode stage.
- Holds them on stall and turns them into a bubble on redirect.
- Contains the static backward-taken/forward-not-taken branch predictor that drives fetch's IF-stage branch request, and tags each captured instruction with its prediction so decode can detect a mispredict.
- Keeps three saturating 16-bit event counters for debug and performance.

Parameters:
- NOP_WORD, 32'h00000000, instruction value inserted on a bubble.
- CNT_W, 16, width of each event counter.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_instr  in  32  instruction word from fetch.
- if_opcplus4  in  32  PC+4 in word units (bits 31:30 zero) from fetch.
- if_back_eret  in  1  fetch's registered eret-return flag.
- ifid_write  in  1  1 = load new values, 0 = hold (hazard-unit stall).
- flush_nbranch  in  1  decode detected a branch mispredict.
- flush_jump  in  1  decode issued J/JAL/JR/JALR redirect.
- flush_cp0  in  1  CP0 interrupt/exception redirect.
- if_branch  out  1  combinational prediction-taken request to fetch.
- id_instr  out  32  registered instruction.
- id_opcplus4  out  32  registered word-unit PC+4.
- id_pred_taken  out  1  registered prediction bit.
- id_valid  out  1  1 = real instruction, 0 = bubble.
- id_back_eret  out  1  registered eret flag.
- cnt_stall  out  CNT_W  cycles with ifid_write=0 and no flush.
- cnt_flush  out  CNT_W  cycles with any flush asserted.
- cnt_pred  out  CNT_W  instructions loaded with pred_taken=1.

Behaviour:
- Reset values, all applied on the next rising edge:
  - id_instr=NOP_WORD, id_opcplus4=0, id_pred_taken=0, id_valid=0, id_back_eret=0.
  - All three counters 0.
- Branch detection (combinational), where op = if_instr[31:26] and rt = if_instr[20:16]:
  - is_br is true for op in {000100, 000101, 000110, 000111}.
  - is_br is also true for op=000001 with rt in {00000, 00001, 10000, 10001}.
- if_branch = is_br & if_instr[15] & ~flush_any, where flush_any = flush_nbranch | flush_jump | flush_cp0.
  - Backward branches are predicted taken, forward branches not taken.
  - No prediction is made while a redirect is in flight, since fetch gives redirects priority anyway.
- Register update priority per edge: reset > flush_any > hold (ifid_write=0) > load.
  - flush_any: bubble. id_instr=NOP_WORD, id_valid=0, id_pred_taken=0, id_back_eret=0; id_opcplus4 keeps if_opcplus4 for debug.
  - Flush wins over simultaneous stall.
  - hold: all id_* registers and the counter inputs keep their values; only cnt_stall increments.
  - load: id_instr=if_instr, id_opcplus4=if_opcplus4, id_pred_taken=if_branch, id_valid=1, id_back_eret=if_back_eret.
- Latency: one cycle from fetch to decode. if_branch is zero-latency.
- Counters:
  - Each counter saturates at all-ones and never wraps.
  - At most one of cnt_stall and cnt_flush increments per cycle.
  - cnt_pred increments only on load with if_branch=1.
  - Counters are cleared only by reset.
- Reset mid-stall or mid-flush: reset overrides; the first edge after reset deasserts performs a normal load if ifid_write=1.
- if_instr is not validated beyond opcode decode; unknown opcodes pass through unchanged.

Decomposition:
- Shared package minisys_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM;
  - REGIMM rt constants RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL;
  - NOP constant.
- One natural sub-module, sat_counter (CNT_W, inc, reset), instantiated three times.
- Predictor decode stays inline.

Test Plan:
- Reset with ifid_write=1 and if_instr=32'h1234_5678 -> after the edge, id_valid=0, id_instr=0 and all counters 0. On the next edge id_instr=32'h1234_5678 and id_valid=1.
- Predictor:
  - if_instr=32'h1000_FFFC (beq, offset -4) -> if_branch=1 that cycle, and id_pred_taken=1 after load.
  - if_instr=32'h1000_0004 -> if_branch=0.
  - if_instr=32'h0411_FFF0 (bgezal, backward) -> if_branch=1.
- Hold ifid_write=0 for 3 cycles with changing if_instr -> id_* frozen and cnt_stall=3. Then ifid_write=1 -> the new instruction loads on the next edge.
- flush_nbranch=1 together with ifid_write=0 and a backward beq on if_instr -> if_branch=0; next edge id_valid=0, id_instr=0, cnt_flush=1 and cnt_stall unchanged.
- flush_cp0 pulse while if_back_eret=1 -> id_back_eret=0. The next normal load with if_back_eret=1 gives id_back_eret=1.
- Force 65540 consecutive stall cycles -> cnt_stall saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/minisys_pkg.sv
// rtl/minisys_pkg.sv - shared opcode/rt decode constants for the minisys pipeline
package minisys_pkg;

    // Primary opcodes of the conditional branches seen by the IF/ID predictor.
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_REGIMM = 6'b000001;

    // REGIMM rt sub-opcodes that are branches.
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // Instruction word used for a pipeline bubble.
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for debug/performance events
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high clear
//   inc    in   count one event this cycle
//   count  out  current value, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with static BTFN branch predictor
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   if_instr, if_opcplus4        fetched instruction and word-unit PC+4
//   if_back_eret                 fetch's eret-return flag
//   ifid_write                   1 = load, 0 = hold (stall)
//   flush_nbranch/jump/cp0       redirect requests; any of them bubbles the stage
//   if_branch                    combinational predict-taken request to fetch
//   id_instr, id_opcplus4,
//   id_pred_taken, id_valid,
//   id_back_eret                 registered values for decode
//   cnt_stall, cnt_flush,
//   cnt_pred                     saturating event counters
module if_id_stage
    import minisys_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_opcplus4,
    input  logic             if_back_eret,
    input  logic             ifid_write,
    input  logic             flush_nbranch,
    input  logic             flush_jump,
    input  logic             flush_cp0,
    output logic             if_branch,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_opcplus4,
    output logic             id_pred_taken,
    output logic             id_valid,
    output logic             id_back_eret,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_pred
);

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic        w_is_br;
    logic        w_flush_any;

    logic [31:0] r_instr;
    logic [31:0] r_opcplus4;
    logic        r_pred_taken;
    logic        r_valid;
    logic        r_back_eret;

    assign w_op        = if_instr[31:26];
    assign w_rt        = if_instr[20:16];
    assign w_flush_any = flush_nbranch | flush_jump | flush_cp0;

    always_comb begin
        w_is_br = 1'b0;
        case (w_op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_is_br = 1'b1;
            OP_REGIMM: w_is_br = (w_rt == RT_BLTZ)   || (w_rt == RT_BGEZ) ||
                                 (w_rt == RT_BLTZAL) || (w_rt == RT_BGEZAL);
            default: w_is_br = 1'b0;
        endcase
    end

    // Offset sign bit selects backward (taken) vs forward (not taken).
    // Suppressed during a redirect: fetch would ignore it anyway.
    assign if_branch = w_is_br & if_instr[15] & ~w_flush_any;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr      <= NOP_WORD;
            r_opcplus4   <= '0;
            r_pred_taken <= 1'b0;
            r_valid      <= 1'b0;
            r_back_eret  <= 1'b0;
        end else if (w_flush_any) begin
            // Bubble; PC+4 still tracks fetch so the squashed slot is traceable.
            r_instr      <= NOP_WORD;
            r_opcplus4   <= if_opcplus4;
            r_pred_taken <= 1'b0;
            r_valid      <= 1'b0;
            r_back_eret  <= 1'b0;
        end else if (ifid_write) begin
            r_instr      <= if_instr;
            r_opcplus4   <= if_opcplus4;
            r_pred_taken <= if_branch;
            r_valid      <= 1'b1;
            r_back_eret  <= if_back_eret;
        end
    end

    assign id_instr      = r_instr;
    assign id_opcplus4   = r_opcplus4;
    assign id_pred_taken = r_pred_taken;
    assign id_valid      = r_valid;
    assign id_back_eret  = r_back_eret;

    // Stall and flush are mutually exclusive because flush dominates stall.
    logic w_inc_stall;
    logic w_inc_flush;
    logic w_inc_pred;

    assign w_inc_stall = ~w_flush_any & ~ifid_write;
    assign w_inc_flush = w_flush_any;
    assign w_inc_pred  = ifid_write & if_branch;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clock (clock),
        .reset (reset),
        .inc   (w_inc_stall),
        .count (cnt_stall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clock (clock),
        .reset (reset),
        .inc   (w_inc_flush),
        .count (cnt_flush)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_pred (
        .clock (clock),
        .reset (reset),
        .inc   (w_inc_pred),
        .count (cnt_pred)
    );

endmodule
